// File: rtl/exec_mem_latch.sv
// Y86-64 execute-to-memory boundary: holds the CC register, evaluates cnd, and latches the E->M register.
// Optional macro UNSIGNED_COND_EN adds the unsigned conditions b (ifun 7) and a (ifun 8) on CF.
module exec_mem_latch #(
  parameter int BIT_WID = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               e_valid,
  input  logic [3:0]         e_icode,
  input  logic [3:0]         e_ifun,
  input  logic [BIT_WID-1:0] e_valE,
  input  logic [BIT_WID-1:0] e_valA,
  input  logic [3:0]         e_dstE,
  input  logic [3:0]         e_dstM,
  input  logic [3:0]         alu_cc,
  input  logic               set_cond,
  input  logic               m_exc,
  input  logic               stall,
  input  logic               bubble,
  output logic [3:0]         cc,
  output logic               cnd,
  output logic               m_valid,
  output logic [3:0]         m_icode,
  output logic               m_cnd,
  output logic [BIT_WID-1:0] m_valE,
  output logic [BIT_WID-1:0] m_valA,
  output logic [3:0]         m_dstE,
  output logic [3:0]         m_dstM
);

  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [3:0] RNONE      = 4'hF;
  localparam logic [3:0] CC_RESET   = 4'b0001;

  logic [3:0]         cc_q, cc_d;
  logic               m_valid_q, m_valid_d;
  logic [3:0]         m_icode_q, m_icode_d;
  logic               m_cnd_q, m_cnd_d;
  logic [BIT_WID-1:0] m_valE_q, m_valE_d;
  logic [BIT_WID-1:0] m_valA_q, m_valA_d;
  logic [3:0]         m_dstE_q, m_dstE_d;
  logic [3:0]         m_dstM_q, m_dstM_d;

  logic zf, sf, of_f, lt;
  logic cnd_c;

  assign zf   = cc_q[0];
  assign sf   = cc_q[1];
  assign of_f = cc_q[2];
  assign lt   = sf ^ of_f;

  // Evaluated on the registered flags only, so an OPq's result reaches the instruction behind it.
  always_comb begin
    cnd_c = 1'b0;
    case (e_ifun)
      4'd0:    cnd_c = 1'b1;
      4'd1:    cnd_c = lt | zf;
      4'd2:    cnd_c = lt;
      4'd3:    cnd_c = zf;
      4'd4:    cnd_c = ~zf;
      4'd5:    cnd_c = ~lt;
      4'd6:    cnd_c = ~lt & ~zf;
`ifdef UNSIGNED_COND_EN
      4'd7:    cnd_c = cc_q[3];
      4'd8:    cnd_c = ~cc_q[3] & ~zf;
`endif
      default: cnd_c = 1'b0;
    endcase
  end

  always_comb begin
    cc_d = cc_q;
    if (set_cond && e_valid && !m_exc && !stall) begin
      cc_d = alu_cc;
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_valE_d  = m_valE_q;
    m_valA_d  = m_valA_q;
    m_dstE_d  = m_dstE_q;
    m_dstM_d  = m_dstM_q;
    if (bubble) begin
      m_valid_d = 1'b0;
      m_icode_d = ICODE_NOP;
      m_cnd_d   = 1'b0;
      m_valE_d  = '0;
      m_valA_d  = '0;
      m_dstE_d  = RNONE;
      m_dstM_d  = RNONE;
    end else if (!stall) begin
      m_valid_d = e_valid;
      m_icode_d = e_icode;
      m_cnd_d   = cnd_c;
      m_valE_d  = e_valE;
      m_valA_d  = e_valA;
      // A cmov whose condition fails must not write its destination.
      m_dstE_d  = (e_icode == ICODE_CMOV && !cnd_c) ? RNONE : e_dstE;
      m_dstM_d  = e_dstM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q      <= CC_RESET;
      m_valid_q <= 1'b0;
      m_icode_q <= ICODE_NOP;
      m_cnd_q   <= 1'b0;
      m_valE_q  <= '0;
      m_valA_q  <= '0;
      m_dstE_q  <= RNONE;
      m_dstM_q  <= RNONE;
    end else begin
      cc_q      <= cc_d;
      m_valid_q <= m_valid_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_valE_q  <= m_valE_d;
      m_valA_q  <= m_valA_d;
      m_dstE_q  <= m_dstE_d;
      m_dstM_q  <= m_dstM_d;
    end
  end

  assign cc      = cc_q;
  assign cnd     = cnd_c;
  assign m_valid = m_valid_q;
  assign m_icode = m_icode_q;
  assign m_cnd   = m_cnd_q;
  assign m_valE  = m_valE_q;
  assign m_valA  = m_valA_q;
  assign m_dstE  = m_dstE_q;
  assign m_dstM  = m_dstM_q;

endmodule

// File: tb/tb_exec_mem_latch.sv
// Directed bench for exec_mem_latch: stimulus pushes hand-computed M-stage/CC expectations,
// a monitor pops and compares them one cycle later.
module tb_exec_mem_latch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        e_valid = 1'b0;
  logic [3:0]  e_icode = 4'h1;
  logic [3:0]  e_ifun = 4'h0;
  logic [63:0] e_valE = '0;
  logic [63:0] e_valA = '0;
  logic [3:0]  e_dstE = 4'hF;
  logic [3:0]  e_dstM = 4'hF;
  logic [3:0]  alu_cc = 4'h0;
  logic        set_cond = 1'b0;
  logic        m_exc = 1'b0;
  logic        stall = 1'b0;
  logic        bubble = 1'b0;
  logic [3:0]  cc;
  logic        cnd;
  logic        m_valid;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [63:0] m_valE;
  logic [63:0] m_valA;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  cc;
    logic        valid;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } exp_t;

  exp_t sb[$];

`ifdef UNSIGNED_COND_EN
  localparam logic B_TAKEN = 1'b1;
`else
  localparam logic B_TAKEN = 1'b0;
`endif

  exec_mem_latch #(.BIT_WID(64)) dut (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM), .alu_cc(alu_cc),
    .set_cond(set_cond), .m_exc(m_exc), .stall(stall), .bubble(bubble), .cc(cc), .cnd(cnd),
    .m_valid(m_valid), .m_icode(m_icode), .m_cnd(m_cnd), .m_valE(m_valE), .m_valA(m_valA),
    .m_dstE(m_dstE), .m_dstM(m_dstM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One E-stage cycle: drive inputs, check cnd combinationally, queue the post-edge expectation.
  task automatic step(
    input logic vld, input logic [3:0] icode, input logic [3:0] ifun,
    input logic [63:0] valE, input logic [63:0] valA, input logic [3:0] dstE, input logic [3:0] dstM,
    input logic [3:0] acc, input logic sc, input logic exc, input logic stl, input logic bub,
    input logic ecnd, input logic [3:0] ecc, input logic emv, input logic [3:0] emicode,
    input logic emcnd, input logic [63:0] emvalE, input logic [63:0] emvalA,
    input logic [3:0] emdstE, input logic [3:0] emdstM);
    exp_t e;
    @(negedge clk);
    e_valid = vld; e_icode = icode; e_ifun = ifun; e_valE = valE; e_valA = valA;
    e_dstE = dstE; e_dstM = dstM; alu_cc = acc; set_cond = sc; m_exc = exc;
    stall = stl; bubble = bub;
    #1;
    chk("cnd", {63'd0, cnd}, {63'd0, ecnd});
    e.cc = ecc; e.valid = emv; e.icode = emicode; e.cnd = emcnd;
    e.valE = emvalE; e.valA = emvalA; e.dstE = emdstE; e.dstM = emdstM;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() != 0) begin
        e = sb.pop_front();
        chk("cc",      {60'd0, cc},      {60'd0, e.cc});
        chk("m_valid", {63'd0, m_valid}, {63'd0, e.valid});
        chk("m_icode", {60'd0, m_icode}, {60'd0, e.icode});
        chk("m_cnd",   {63'd0, m_cnd},   {63'd0, e.cnd});
        chk("m_valE",  m_valE,           e.valE);
        chk("m_valA",  m_valA,           e.valA);
        chk("m_dstE",  {60'd0, m_dstE},  {60'd0, e.dstE});
        chk("m_dstM",  {60'd0, m_dstM},  {60'd0, e.dstM});
      end
    end
  end

  initial begin : stim
    int budget;
    // Reset asserted mid-cycle: state must be at reset value before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cc", {60'd0, cc}, 64'h1);
    chk("rst_m_icode", {60'd0, m_icode}, 64'h1);
    chk("rst_m_dstE", {60'd0, m_dstE}, 64'hF);
    chk("rst_m_valid", {63'd0, m_valid}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //   vld icode ifun valE     valA     dstE  dstM  alu_cc   sc exc stl bub | cnd  cc       mv icode cnd valE     valA     dstE  dstM
    // OPq setting SF=OF=1
    step(1, 4'h6, 4'h0, 64'h10,  64'h20,  4'h3, 4'hF, 4'b0110, 1, 0, 0, 0,   1, 4'b0110, 1, 4'h6, 1, 64'h10,  64'h20,  4'h3, 4'hF);
    // jle right behind: (SF^OF)|ZF = 0
    step(1, 4'h7, 4'h1, 64'h0,   64'h40,  4'hF, 4'hF, 4'b0000, 0, 0, 0, 0,   0, 4'b0110, 1, 4'h7, 0, 64'h0,   64'h40,  4'hF, 4'hF);
    // cmove with ZF=0: squashed destination
    step(1, 4'h2, 4'h3, 64'h55,  64'h55,  4'h3, 4'hF, 4'b0000, 0, 0, 0, 0,   0, 4'b0110, 1, 4'h2, 0, 64'h55,  64'h55,  4'hF, 4'hF);
    // OPq setting ZF=1; jle-style cnd still sees old flags
    step(1, 4'h6, 4'h1, 64'h0,   64'h7,   4'h4, 4'hF, 4'b0001, 1, 0, 0, 0,   0, 4'b0001, 1, 4'h6, 0, 64'h0,   64'h7,   4'h4, 4'hF);
    // cmove with ZF=1: destination kept
    step(1, 4'h2, 4'h3, 64'h99,  64'h99,  4'h3, 4'hF, 4'b0000, 0, 0, 0, 0,   1, 4'b0001, 1, 4'h2, 1, 64'h99,  64'h99,  4'h3, 4'hF);
    // exception downstream blocks the CC write
    step(1, 4'h6, 4'h0, 64'hAA,  64'h0,   4'h5, 4'hF, 4'b1000, 1, 1, 0, 0,   1, 4'b0001, 1, 4'h6, 1, 64'hAA,  64'h0,   4'h5, 4'hF);
    // three stall cycles: M frozen, CC untouched
    for (int i = 0; i < 3; i++)
      step(1, 4'h6, 4'h4, 64'hBB, 64'h1, 4'h6, 4'hF, 4'b1010, 1, 0, 1, 0,   0, 4'b0001, 1, 4'h6, 1, 64'hAA,  64'h0,   4'h5, 4'hF);
    // bubble wins over stall
    step(1, 4'h6, 4'h0, 64'hCC,  64'h2,   4'h6, 4'hF, 4'b1010, 1, 0, 1, 1,   1, 4'b0001, 0, 4'h1, 0, 64'h0,   64'h0,   4'hF, 4'hF);
    // OPq setting CF only; l evaluates to 0 on ZF-only flags
    step(1, 4'h6, 4'h2, 64'h123, 64'h456, 4'h7, 4'hF, 4'b1000, 1, 0, 0, 0,   0, 4'b1000, 1, 4'h6, 0, 64'h123, 64'h456, 4'h7, 4'hF);
    // unsigned below with CF=1
    step(1, 4'h7, 4'h7, 64'h0,   64'h800, 4'hF, 4'hF, 4'b0000, 0, 0, 0, 0,   B_TAKEN, 4'b1000, 1, 4'h7, B_TAKEN, 64'h0, 64'h800, 4'hF, 4'hF);
    // invalid E: fields pass through, CC not written
    step(0, 4'h5, 4'h0, 64'h77,  64'h88,  4'hF, 4'h2, 4'b0100, 1, 0, 0, 0,   1, 4'b1000, 0, 4'h5, 1, 64'h77,  64'h88,  4'hF, 4'h2);
    // g with SF=OF=ZF=0
    step(1, 4'h7, 4'h6, 64'h0,   64'h900, 4'hF, 4'hF, 4'b0000, 0, 0, 0, 0,   1, 4'b1000, 1, 4'h7, 1, 64'h0,   64'h900, 4'hF, 4'hF);
    // unsigned above fails with CF=1
    step(1, 4'h7, 4'h8, 64'h0,   64'hA00, 4'hF, 4'hF, 4'b0000, 0, 0, 0, 0,   0, 4'b1000, 1, 4'h7, 0, 64'h0,   64'hA00, 4'hF, 4'hF);
    // reserved ifun 9
    step(1, 4'h7, 4'h9, 64'h0,   64'hB00, 4'hF, 4'hF, 4'b0000, 0, 0, 0, 0,   0, 4'b1000, 1, 4'h7, 0, 64'h0,   64'hB00, 4'hF, 4'hF);

    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    @(posedge clk);

    // Reset mid-operation with a CC-writing OPq in E.
    @(negedge clk);
    e_valid = 1'b1; e_icode = 4'h6; e_ifun = 4'h0; e_valE = 64'hDEAD; e_dstE = 4'h2;
    alu_cc = 4'b0110; set_cond = 1'b1; stall = 1'b0; bubble = 1'b0; m_exc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cc", {60'd0, cc}, 64'h1);
    chk("mid_rst_m_valid", {63'd0, m_valid}, 64'h0);
    chk("mid_rst_m_icode", {60'd0, m_icode}, 64'h1);
    chk("mid_rst_m_valE", m_valE, 64'h0);
    chk("mid_rst_m_dstE", {60'd0, m_dstE}, 64'hF);
    chk("mid_rst_m_dstM", {60'd0, m_dstM}, 64'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
